regfile_master: RTL and testbench
=================================

REGFILE_MASTER -- requirements
Module: regfile_master

Interface
REQ-001 Parameter ADDR_W, default 5, SHALL set the word-address width of the target register file.
REQ-002 Parameter DATA_W, default 32, SHALL set the data width; DATA_W/8 SHALL set the byteenable width.
REQ-003 clk_clk  input  1  single clock; all logic SHALL be clocked on the rising edge.
REQ-004 reset_reset  input  1  reset, synchronous and active-high.
REQ-005 cmd_valid/cmd_ready  in/out  1/1  command handshake.
REQ-006 cmd_write  input  1  1 selects a write burst, 0 selects a read burst.
REQ-007 cmd_addr  input  ADDR_W  start word address.
REQ-008 cmd_len  input  ADDR_W  burst length minus one (0 to 31, giving 1 to 32 words).
REQ-009 wr_valid/wr_ready/wr_data  in/out/in  1/1/DATA_W  write-data stream.
REQ-010 rd_valid/rd_ready/rd_data  out/in/out  1/1/DATA_W  read-data stream.
REQ-011 busy/done  output  1/1  busy = a burst is in progress; done = one-cycle pulse when a burst completes.
REQ-012 mem_address, mem_clken, mem_chipselect, mem_write, mem_writedata, mem_byteenable  output  ADDR_W/1/1/1/DATA_W/(DATA_W/8)  Avalon-MM master port toward the on-chip register file.
REQ-013 mem_readdata  input  DATA_W  read data returned by the slave with fixed read latency 1.

Function
REQ-014 The FSM SHALL have the states IDLE, WRITE, READ and DRAIN.
REQ-015 IDLE: cmd_ready SHALL be 1; on cmd_valid&cmd_ready the block SHALL latch the address and count and go to WRITE or READ according to cmd_write.
REQ-016 WRITE: wr_ready SHALL be 1; on each wr_valid beat, in that same cycle, mem_chipselect=1, mem_write=1, mem_address=current address and mem_writedata=wr_data.
REQ-017 WRITE: after the beat where count reaches zero the FSM SHALL go to IDLE with done=1 on the next cycle.
REQ-018 READ: while not stalled, each cycle SHALL issue chipselect=1, write=0 at the current address; rd_valid SHALL be 1 in the cycle after an issue.
REQ-019 rd_data SHALL equal mem_readdata (combinational pass-through).
REQ-020 A stall is rd_valid&~rd_ready; during a stall mem_clken SHALL be 0, mem_address SHALL be held and no new issue SHALL occur, so rd_data stays stable.
REQ-021 mem_clken SHALL be 1 at all other times.
REQ-022 After the last issue the FSM SHALL go to DRAIN; on acceptance of the last rd beat it SHALL go to IDLE with done=1.
REQ-023 Throughput SHALL be one word per cycle without backpressure.
REQ-024 The address SHALL increment by 1 per beat modulo 2^ADDR_W (31 wraps to 0).
REQ-025 When no access is issued, mem_chipselect and mem_write SHALL be 0.
REQ-026 wr_ready SHALL be 0 outside WRITE; cmd_ready SHALL be 0 outside IDLE; rd_valid SHALL never be 1 outside READ/DRAIN.
REQ-027 busy SHALL be 1 in every state except IDLE.

Reset
REQ-028 While reset_reset=1 the block SHALL hold cmd_ready=0.
REQ-029 On the first edge with reset_reset=1, state SHALL become IDLE and rd_valid, done, busy, mem_chipselect and mem_write SHALL become 0; mem_address and the count SHALL become 0.
REQ-030 Reset mid-burst SHALL abandon the burst without a done pulse; any pending read data SHALL be discarded.

Configuration
REQ-031 With REGFILE_MASTER_BYTEEN_EN defined, input wr_be (DATA_W/8) SHALL be added and SHALL drive mem_byteenable on each write beat.
REQ-032 Without REGFILE_MASTER_BYTEEN_EN, wr_be SHALL be absent and mem_byteenable SHALL be all ones.
REQ-033 In both builds, mem_byteenable SHALL be all ones on reads.

Structure
REQ-034 Package regfile_master_pkg SHALL hold the state enum and the default ADDR_W/DATA_W constants.
REQ-035 The block SHALL be a single module with no sub-module; the address/count logic SHALL be inline.

Verification
REQ-036 Single write: write cmd, addr 3, len 0, wr_data 0xDEADBEEF -> one cycle with chipselect=1, write=1, address=3; done the next cycle.
REQ-037 Wrap burst: write cmd, addr 30, len 3 -> addresses 30, 31, 0, 1 on successive cycles; then a read of the same range returns the 4 values in order.
REQ-038 Backpressure: read cmd, addr 0, len 7, rd_ready low for 3 cycles mid-burst -> mem_clken=0 for those 3 cycles, address held, rd_data stable, all 8 words delivered exactly once.
REQ-039 Write stall: wr_valid deasserted on alternate cycles -> no mem access in the idle cycles; the burst finishes after 2*len+1 cycles.
REQ-040 Reset mid-read: read cmd, addr 0, len 31; reset at beat 10 -> next cycle state IDLE, rd_valid=0, done never pulses, and a new command is accepted after release.
REQ-041 Byteenable (REGFILE_MASTER_BYTEEN_EN defined): write 0x11223344 with wr_be 4'b0101 -> mem_byteenable=4'b0101; without the macro, mem_byteenable=4'b1111.

Source files
------------

// File: rtl/regfile_master_pkg.sv
// Shared types and default sizes for the register-file burst master.
// Optional byte-enable support is selected with REGFILE_MASTER_BYTEEN_EN.
package regfile_master_pkg;

  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/regfile_master_if.sv
// Command, data-stream and Avalon-MM signals of the register-file burst master.
// REGFILE_MASTER_BYTEEN_EN adds the per-beat write byte enable wr_be.
interface regfile_master_if
  import regfile_master_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W-1:0] cmd_len;

  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
`ifdef REGFILE_MASTER_BYTEEN_EN
  logic [BE_W-1:0]   wr_be;
`endif

  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;

  logic              busy;
  logic              done;

  logic [ADDR_W-1:0] mem_address;
  logic              mem_clken;
  logic              mem_chipselect;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic [BE_W-1:0]   mem_byteenable;
  logic [DATA_W-1:0] mem_readdata;

  modport master (
`ifdef REGFILE_MASTER_BYTEEN_EN
    input  wr_be,
`endif
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  wr_valid, wr_data, rd_ready, mem_readdata,
    output cmd_ready, wr_ready, rd_valid, rd_data, busy, done,
    output mem_address, mem_clken, mem_chipselect, mem_write,
    output mem_writedata, mem_byteenable
  );

  modport slave (
`ifdef REGFILE_MASTER_BYTEEN_EN
    output wr_be,
`endif
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    output wr_valid, wr_data, rd_ready, mem_readdata,
    input  cmd_ready, wr_ready, rd_valid, rd_data, busy, done,
    input  mem_address, mem_clken, mem_chipselect, mem_write,
    input  mem_writedata, mem_byteenable
  );

endinterface

// File: rtl/regfile_master.sv
// Burst master: turns write/read burst commands into single-word Avalon-MM
// accesses to a latency-1 register file. REGFILE_MASTER_BYTEEN_EN enables wr_be.
module regfile_master
  import regfile_master_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  regfile_master_if.master  bus
);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] count;
  logic              rd_valid_q;
  logic              done_q;

  logic              stall;
  logic              beat;
  logic              issue;

  // A held read beat freezes the slave (clken low) so its output stays put.
  assign stall = rd_valid_q & ~bus.rd_ready;
  assign beat  = (state == WRITE) & bus.wr_valid;
  assign issue = (state == READ) & ~stall;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state      <= IDLE;
      addr       <= '0;
      count      <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            addr  <= bus.cmd_addr;
            count <= bus.cmd_len;
            state <= bus.cmd_write ? WRITE : READ;
          end
        end
        WRITE: begin
          if (bus.wr_valid) begin
            addr <= addr + ADDR_W'(1);
            if (count == '0) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end else begin
              count <= count - ADDR_W'(1);
            end
          end
        end
        READ: begin
          if (!stall) begin
            rd_valid_q <= 1'b1;
            addr       <= addr + ADDR_W'(1);
            if (count == '0) begin
              state <= DRAIN;
            end else begin
              count <= count - ADDR_W'(1);
            end
          end
        end
        DRAIN: begin
          // Only the final issued word is outstanding here.
          if (bus.rd_ready) begin
            rd_valid_q <= 1'b0;
            state      <= IDLE;
            done_q     <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready      = (state == IDLE) & ~reset_reset;
  assign bus.wr_ready       = (state == WRITE);
  assign bus.rd_valid       = rd_valid_q;
  assign bus.rd_data        = bus.mem_readdata;
  assign bus.busy           = (state != IDLE);
  assign bus.done           = done_q;

  assign bus.mem_address    = addr;
  assign bus.mem_clken      = ~stall;
  assign bus.mem_chipselect = beat | issue;
  assign bus.mem_write      = beat;
  assign bus.mem_writedata  = bus.wr_data;
`ifdef REGFILE_MASTER_BYTEEN_EN
  assign bus.mem_byteenable = beat ? bus.wr_be : '1;
`else
  assign bus.mem_byteenable = '1;
`endif

endmodule

// File: tb/tb_regfile_master.sv
// Bench for regfile_master: directed vector table, reset-abort sequence and
// random bursts checked against a word-array model of the register file.
`timescale 1ns/1ps
module tb_regfile_master;
  import regfile_master_pkg::*;

  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;
  localparam int unsigned BW    = DW / 8;
  localparam int unsigned DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_init = 1'b1;
  always #5 clk = ~clk;

  regfile_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  regfile_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .bus         (bus)
  );

  int errors = 0;
  int checks = 0;

  function automatic logic [DW-1:0] init_word(input int i);
    return DW'(32'h9E37_79B9 * (i + 1));
  endfunction

  // Latency-1 slave register file with clock enable.
  logic [DW-1:0] smem [DEPTH];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < int'(DEPTH); i++) smem[i] <= init_word(i);
    end else if (bus.mem_clken && bus.mem_chipselect) begin
      if (bus.mem_write) begin
        for (int b = 0; b < int'(BW); b++)
          if (bus.mem_byteenable[b]) smem[bus.mem_address][8*b +: 8] <= bus.mem_writedata[8*b +: 8];
      end else begin
        bus.mem_readdata <= smem[bus.mem_address];
      end
    end
  end

  // Expected register file contents, updated per accepted write word.
  logic [DW-1:0] ref_mem [DEPTH];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input bit wr, input int a, input int len);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = AW'(a);
    bus.cmd_len   = AW'(len);
    @(negedge clk);
    chk("cmd_ready", 64'(bus.cmd_ready), 64'(1));
    chk("idle_busy", 64'({bus.busy, bus.wr_ready, bus.rd_valid}), 64'(0));
    step();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic write_burst(input int a, input int len, input int mode,
                             input logic [BW-1:0] be, input logic [DW-1:0] d0, input bit use_d0);
    logic [DW-1:0] d;
    logic [BW-1:0] ebe;
    int ad;
    send_cmd(1'b1, a, len);
    for (int i = 0; i <= len; i++) begin
      ad = (a + i) % int'(DEPTH);
      if ((mode == 1 && i > 0) || (mode == 2 && $urandom_range(0, 1) == 1)) begin
        bus.wr_valid = 1'b0;
        @(negedge clk);
        chk("wr_gap_idle", 64'({bus.mem_chipselect, bus.mem_write, bus.done}), 64'(0));
        chk("wr_gap_ready", 64'(bus.wr_ready), 64'(1));
        step();
      end
      d = (i == 0 && use_d0) ? d0 : DW'($urandom());
`ifdef REGFILE_MASTER_BYTEEN_EN
      ebe = be;
      bus.wr_be = be;
`else
      ebe = '1;
`endif
      bus.wr_valid = 1'b1;
      bus.wr_data  = d;
      @(negedge clk);
      chk("wr_beat_ctl", 64'({bus.wr_ready, bus.mem_chipselect, bus.mem_write, bus.mem_clken, bus.done}),
          64'(5'b11110));
      chk("wr_addr", 64'(bus.mem_address), 64'(ad));
      chk("wr_data", 64'(bus.mem_writedata), 64'(d));
      chk("wr_byteenable", 64'(bus.mem_byteenable), 64'(ebe));
      for (int b = 0; b < int'(BW); b++)
        if (ebe[b]) ref_mem[ad][8*b +: 8] = d[8*b +: 8];
      step();
    end
    bus.wr_valid = 1'b0;
    @(negedge clk);
    chk("wr_done", 64'({bus.done, bus.busy, bus.wr_ready}), 64'(3'b100));
    step();
    @(negedge clk);
    chk("wr_done_pulse", 64'(bus.done), 64'(0));
    step();
  endtask

  // mode 0: always ready, 1: ready low for cycles 3..5, 2: random ready.
  task automatic read_burst(input int a, input int len, input int mode, input int exp_cyc, input int abort);
    logic [DW-1:0] exq [$];
    int c, issued, got, nstall;
    bit done_seen, stall;
    for (int i = 0; i <= len; i++) exq.push_back(ref_mem[(a + i) % int'(DEPTH)]);
    send_cmd(1'b0, a, len);
    c = 0; issued = 0; got = 0; nstall = 0; done_seen = 1'b0;
    while (!done_seen && c < 200) begin
      bus.rd_ready = (mode == 0) ? 1'b1 : (mode == 1) ? !(c >= 3 && c <= 5) : ($urandom_range(0, 3) != 0);
      @(negedge clk);
      stall = bus.rd_valid && !bus.rd_ready;
      if (bus.done) begin
        done_seen = 1'b1;
        chk("rd_done_cycle", 64'(c), 64'((exp_cyc >= 0) ? exp_cyc : len + 2 + nstall));
        chk("rd_done_state", 64'({bus.busy, bus.rd_valid}), 64'(0));
        chk("rd_words", 64'(got), 64'(len + 1));
      end else begin
        if (stall) begin
          chk("stall_ctl", 64'({bus.mem_clken, bus.mem_chipselect}), 64'(0));
          chk("stall_addr", 64'(bus.mem_address), 64'((a + issued) % int'(DEPTH)));
          nstall++;
        end else begin
          chk("rd_clken", 64'(bus.mem_clken), 64'(1));
        end
        if (bus.mem_chipselect) begin
          chk("rd_issue", 64'({bus.mem_write, bus.mem_byteenable}), 64'({1'b0, {BW{1'b1}}}));
          chk("rd_addr", 64'(bus.mem_address), 64'((a + issued) % int'(DEPTH)));
          issued++;
        end
        if (bus.rd_valid) begin
          if (got <= len) chk("rd_data", 64'(bus.rd_data), 64'(exq[got]));
          else chk("rd_extra_beat", 64'(got), 64'(len));
          if (bus.rd_ready) got++;
        end
        if (abort >= 0 && got == abort) break;
      end
      step();
      c++;
    end
    if (abort >= 0) begin
      step();
      rst = 1'b1;
      bus.rd_ready = 1'b1;
      @(negedge clk);
      chk("rst_cmd_ready", 64'({bus.cmd_ready, bus.done}), 64'(0));
      step();
      @(negedge clk);
      chk("rst_abort_state", 64'({bus.busy, bus.rd_valid, bus.done, bus.mem_chipselect, bus.mem_write}), 64'(0));
      chk("rst_abort_addr", 64'(bus.mem_address), 64'(0));
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst", 64'({bus.cmd_ready, bus.busy, bus.done, bus.rd_valid}), 64'(4'b1000));
      step();
    end else if (!done_seen) begin
      chk("rd_timeout", 64'(done_seen), 64'(1));
    end else begin
      @(negedge clk);
      chk("rd_done_pulse", 64'(bus.done), 64'(0));
      step();
    end
  endtask

  typedef struct {
    bit            wr;
    int            addr;
    int            len;
    int            mode;
    logic [BW-1:0] be;
    logic [DW-1:0] d0;
    bit            use_d0;
    int            exp_cyc;
    int            abort;
  } vec_t;

  vec_t vt [11];

  initial begin
    int a, l, m;
    vt[0]  = '{1'b1,  3,  0, 0, '1,            32'hDEAD_BEEF, 1'b1, -1, -1};
    vt[1]  = '{1'b1, 30,  3, 0, '1,            32'h0,         1'b0, -1, -1};
    vt[2]  = '{1'b0, 30,  3, 0, '1,            32'h0,         1'b0,  5, -1};
    vt[3]  = '{1'b0,  0,  7, 1, '1,            32'h0,         1'b0, 12, -1};
    vt[4]  = '{1'b1,  5,  4, 1, '1,            32'h0,         1'b0, -1, -1};
    vt[5]  = '{1'b0,  5,  4, 0, '1,            32'h0,         1'b0,  6, -1};
    vt[6]  = '{1'b1,  8,  0, 0, BW'(4'b0101),  32'h1122_3344, 1'b1, -1, -1};
    vt[7]  = '{1'b0,  8,  0, 0, '1,            32'h0,         1'b0,  2, -1};
    vt[8]  = '{1'b0,  0, 31, 0, '1,            32'h0,         1'b0, -1, 10};
    vt[9]  = '{1'b1, 12,  2, 0, '1,            32'h0,         1'b0, -1, -1};
    vt[10] = '{1'b0, 12,  2, 2, '1,            32'h0,         1'b0, -1, -1};

    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = init_word(i);
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.wr_valid = 1'b0; bus.wr_data = '0; bus.rd_ready = 1'b1;
`ifdef REGFILE_MASTER_BYTEEN_EN
    bus.wr_be = '1;
`endif

    @(negedge clk);
    chk("rst_hold_cmd_ready", 64'(bus.cmd_ready), 64'(0));
    step();
    step();
    @(negedge clk);
    chk("rst_outputs", 64'({bus.busy, bus.done, bus.rd_valid, bus.mem_chipselect, bus.mem_write,
                           bus.wr_ready, bus.cmd_ready}), 64'(0));
    chk("rst_addr", 64'(bus.mem_address), 64'(0));
    chk("rst_clken_be", 64'({bus.mem_clken, bus.mem_byteenable}), 64'({1'b1, {BW{1'b1}}}));
    step();
    rst = 1'b0;
    mem_init = 1'b0;
    step();

    for (int v = 0; v < 11; v++) begin
      if (vt[v].wr) write_burst(vt[v].addr, vt[v].len, vt[v].mode, vt[v].be, vt[v].d0, vt[v].use_d0);
      else          read_burst(vt[v].addr, vt[v].len, vt[v].mode, vt[v].exp_cyc, vt[v].abort);
    end

    for (int k = 0; k < 24; k++) begin
      a = $urandom_range(0, 31);
      l = $urandom_range(0, 31);
      m = $urandom_range(0, 2);
      if ($urandom_range(0, 1) == 1) write_burst(a, l, m, BW'($urandom()), '0, 1'b0);
      else                           read_burst(a, l, m, -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
